// File: rtl/sprite_line_fetcher_if.sv
`default_nettype none
// ============================================================================
// Module   : sprite_line_fetcher_if
// Brief    : Shared bitmap-lookup port between the line fetcher and the
//            combinational sprite bitmap mux.
// Revision : 1.0 - initial release
// ============================================================================
interface sprite_line_fetcher_if;
  logic [1:0] rom_sel;
  logic [9:0] rom_x;
  logic [9:0] rom_y;
  logic       rom_bit;

  modport master (output rom_sel, output rom_x, output rom_y, input rom_bit);
  modport slave  (input rom_sel, input rom_x, input rom_y, output rom_bit);
endinterface
`default_nettype wire

// File: rtl/sprite_line_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : sprite_line_fetcher
// Brief    : Fetches enabled sprite rows during hblank into a shadow buffer and
//            resolves per-pixel hits from a double-buffered active copy.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_line_fetcher #(
  parameter int NUM_SLOTS = 4,
  parameter int SPRITE_W  = 16,
  parameter int SPRITE_H  = 16
) (
  input  wire logic                    Clk,
  input  wire logic                    Reset_n,
  input  wire logic                    line_start,
  input  wire logic [9:0]              next_line,
  input  wire logic [NUM_SLOTS-1:0]    slot_en,
  input  wire logic [2*NUM_SLOTS-1:0]  slot_sel,
  input  wire logic [10*NUM_SLOTS-1:0] slot_x,
  input  wire logic [10*NUM_SLOTS-1:0] slot_y,
  sprite_line_fetcher_if.master        rom,
  input  wire logic [9:0]              DrawX,
  output logic                         busy,
  output logic                         overrun,
  output logic                         pix_hit,
  output logic [2:0]                   pix_slot
);

  localparam int c_SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int c_COL_W  = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_FETCH = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  // Fetch context, frozen at line_start
  logic [NUM_SLOTS-1:0] r_ctx_en;
  logic [1:0]           r_ctx_sel [NUM_SLOTS];
  logic [9:0]           r_ctx_x   [NUM_SLOTS];
  logic [9:0]           r_ctx_y   [NUM_SLOTS];
  logic [9:0]           r_ctx_line;

  logic [c_SLOT_W-1:0]  r_slot;
  logic [c_COL_W-1:0]   r_col;
  logic                 r_done;

  logic [SPRITE_W-1:0]  r_sh_row  [NUM_SLOTS];
  logic [9:0]           r_sh_x    [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] r_sh_valid;
  logic [SPRITE_W-1:0]  r_act_row [NUM_SLOTS];
  logic [9:0]           r_act_x   [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] r_act_valid;

  logic                 r_overrun;
  logic                 r_pix_hit;
  logic [2:0]           r_pix_slot;

  logic [9:0]           w_row;
  logic                 w_slot_hit;
  logic                 w_last_slot;
  logic                 w_last_col;
  logic [9:0]           w_off;
  logic                 w_hit;
  logic [2:0]           w_slot;

  // Row arithmetic is mod 1024 so sprites straddling line 0 still hit
  assign w_row       = r_ctx_line - r_ctx_y[r_slot];
  assign w_slot_hit  = r_ctx_en[r_slot] && (r_ctx_sel[r_slot] != 2'd3) &&
                       (w_row < 10'(SPRITE_H));
  assign w_last_slot = (r_slot == c_SLOT_W'(NUM_SLOTS - 1));
  assign w_last_col  = (r_col == c_COL_W'(SPRITE_W - 1));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state != S_IDLE);
    rom.rom_sel = 2'd0;
    rom.rom_x   = 10'd0;
    rom.rom_y   = 10'd0;
    case (r_state)
      S_CHECK: begin
        if (w_slot_hit)       w_state_nxt = S_FETCH;
        else if (w_last_slot) w_state_nxt = S_IDLE;
      end
      S_FETCH: begin
        rom.rom_sel = r_ctx_sel[r_slot];
        rom.rom_x   = 10'(r_col);
        rom.rom_y   = w_row;
        if (w_last_col) w_state_nxt = w_last_slot ? S_IDLE : S_CHECK;
      end
      default: ;
    endcase
    if (line_start) w_state_nxt = S_CHECK;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_ctx_en    <= '0;
      r_ctx_line  <= '0;
      r_slot      <= '0;
      r_col       <= '0;
      r_done      <= 1'b1;
      r_sh_valid  <= '0;
      r_act_valid <= '0;
      r_overrun   <= 1'b0;
      r_pix_hit   <= 1'b0;
      r_pix_slot  <= 3'd0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        r_ctx_sel[s] <= '0;
        r_ctx_x[s]   <= '0;
        r_ctx_y[s]   <= '0;
        r_sh_row[s]  <= '0;
        r_sh_x[s]    <= '0;
        r_act_row[s] <= '0;
        r_act_x[s]   <= '0;
      end
    end else begin
      r_overrun  <= line_start && busy;
      r_pix_hit  <= w_hit;
      r_pix_slot <= w_slot;
      if (line_start) begin
        // An abandoned fetch never reaches the active copy
        if (r_done) begin
          r_act_valid <= r_sh_valid;
          for (int s = 0; s < NUM_SLOTS; s++) begin
            r_act_row[s] <= r_sh_row[s];
            r_act_x[s]   <= r_sh_x[s];
          end
        end
        r_done     <= 1'b0;
        r_slot     <= '0;
        r_col      <= '0;
        r_ctx_en   <= slot_en;
        r_ctx_line <= next_line;
        for (int s = 0; s < NUM_SLOTS; s++) begin
          r_ctx_sel[s] <= slot_sel[2*s +: 2];
          r_ctx_x[s]   <= slot_x[10*s +: 10];
          r_ctx_y[s]   <= slot_y[10*s +: 10];
        end
      end else if (r_state == S_CHECK) begin
        if (w_slot_hit) begin
          r_col          <= '0;
          r_sh_x[r_slot] <= r_ctx_x[r_slot];
        end else begin
          r_sh_valid[r_slot] <= 1'b0;
          if (w_last_slot) r_done <= 1'b1;
          else             r_slot <= r_slot + c_SLOT_W'(1);
        end
      end else if (r_state == S_FETCH) begin
        r_sh_row[r_slot][r_col] <= rom.rom_bit;
        if (w_last_col) begin
          r_sh_valid[r_slot] <= 1'b1;
          r_col              <= '0;
          if (w_last_slot) r_done <= 1'b1;
          else             r_slot <= r_slot + c_SLOT_W'(1);
        end else begin
          r_col <= r_col + c_COL_W'(1);
        end
      end
    end
  end

  // Descending scan leaves the lowest hitting slot as the winner
  always_comb begin
    w_hit  = 1'b0;
    w_slot = 3'd0;
    w_off  = 10'd0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      w_off = DrawX - r_act_x[s];
      if (r_act_valid[s] && (w_off < 10'(SPRITE_W)) &&
          r_act_row[s][w_off[c_COL_W-1:0]]) begin
        w_hit  = 1'b1;
        w_slot = 3'(s);
      end
    end
  end

  assign overrun  = r_overrun;
  assign pix_hit  = r_pix_hit;
  assign pix_slot = r_pix_slot;

endmodule
`default_nettype wire

// File: tb/tb_sprite_line_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_line_fetcher
// Brief    : Self-checking bench with a schedule/array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_line_fetcher;
  localparam int N = 4;
  localparam int W = 16;
  localparam int H = 16;

  logic            Clk = 1'b0;
  logic            Reset_n = 1'b0;
  logic            line_start = 1'b0;
  logic [9:0]      next_line = '0;
  logic [9:0]      DrawX = '0;
  logic [N-1:0]    slot_en = '0;
  logic [2*N-1:0]  slot_sel = '0;
  logic [10*N-1:0] slot_x = '0;
  logic [10*N-1:0] slot_y = '0;
  logic            busy, overrun, pix_hit;
  logic [2:0]      pix_slot;

  sprite_line_fetcher_if rif();

  sprite_line_fetcher #(.NUM_SLOTS(N), .SPRITE_W(W), .SPRITE_H(H)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .line_start(line_start), .next_line(next_line),
    .slot_en(slot_en), .slot_sel(slot_sel), .slot_x(slot_x), .slot_y(slot_y),
    .rom(rif), .DrawX(DrawX), .busy(busy), .overrun(overrun),
    .pix_hit(pix_hit), .pix_slot(pix_slot)
  );

  always #5 Clk = ~Clk;

  // Bitmaps: column c of a row is bit 15-c (leftmost pixel on the MSB side)
  logic [15:0] bmp [0:3][0:15];
  assign rif.rom_bit = (rif.rom_sel != 2'd3 && rif.rom_x < 10'd16 && rif.rom_y < 10'd16) ?
                       bmp[rif.rom_sel][rif.rom_y[3:0]][4'd15 - rif.rom_x[3:0]] : 1'b0;

  int n_checks = 0;
  int n_err    = 0;

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0] sel;
    logic [9:0] x;
    logic [9:0] y;
  } ent_t;

  ent_t        sched[$];          // expected rom outputs, one entry per busy cycle
  logic        m_sh_valid [N];
  logic [9:0]  m_sh_x     [N];
  logic [15:0] m_sh_row   [N];
  logic        m_act_valid[N];
  logic [9:0]  m_act_x    [N];
  logic [15:0] m_act_row  [N];
  logic        m_ovr, m_hit;
  logic [2:0]  m_slot;
  bit          m_was_busy;
  logic [9:0]  m_off, m_row;
  logic [1:0]  m_sel;
  ent_t        m_e;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sched.delete();
      for (int s = 0; s < N; s++) begin
        m_sh_valid[s] = 0; m_sh_x[s] = 0; m_sh_row[s] = 0;
        m_act_valid[s] = 0; m_act_x[s] = 0; m_act_row[s] = 0;
      end
      m_ovr = 0; m_hit = 0; m_slot = 0;
    end else begin
      m_was_busy = (sched.size() != 0);
      m_hit = 0; m_slot = 0;
      for (int s = N - 1; s >= 0; s--) begin
        m_off = DrawX - m_act_x[s];
        if (m_act_valid[s] && m_off < 10'd16 && m_act_row[s][m_off[3:0]]) begin
          m_hit = 1; m_slot = 3'(s);
        end
      end
      m_ovr = line_start && m_was_busy;
      if (m_was_busy) void'(sched.pop_front());
      if (line_start) begin
        if (!m_was_busy)
          for (int s = 0; s < N; s++) begin
            m_act_valid[s] = m_sh_valid[s];
            m_act_x[s]     = m_sh_x[s];
            m_act_row[s]   = m_sh_row[s];
          end
        sched.delete();
        for (int s = 0; s < N; s++) begin
          m_sel = slot_sel[2*s +: 2];
          m_row = next_line - slot_y[10*s +: 10];
          m_e = '0;
          sched.push_back(m_e);
          if (slot_en[s] && m_sel != 2'd3 && m_row < 10'(H)) begin
            for (int c = 0; c < W; c++) begin
              m_e.sel = m_sel; m_e.x = 10'(c); m_e.y = m_row;
              sched.push_back(m_e);
              m_sh_row[s][c] = bmp[m_sel][m_row[3:0]][15 - c];
            end
            m_sh_x[s]     = slot_x[10*s +: 10];
            m_sh_valid[s] = 1;
          end else begin
            m_sh_valid[s] = 0;
          end
        end
      end
    end
  end

  ent_t c_e;
  always @(negedge Clk) begin
    if (Reset_n) begin
      c_e = (sched.size() != 0) ? sched[0] : '0;
      chk("busy",     busy,        int'(sched.size() != 0));
      chk("rom_sel",  rif.rom_sel, c_e.sel);
      chk("rom_x",    rif.rom_x,   c_e.x);
      chk("rom_y",    rif.rom_y,   c_e.y);
      chk("overrun",  overrun,     m_ovr);
      chk("pix_hit",  pix_hit,     m_hit);
      chk("pix_slot", pix_slot,    m_slot);
    end
  end

  // ---------------- stimulus helpers ----------------
  int          cnt, mx_x, mx_y, outside;
  logic [15:0] mask;

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic set_slot(int s, bit en, int sel, int x, int y);
    slot_en[s]          = en;
    slot_sel[2*s +: 2]  = 2'(sel);
    slot_x[10*s +: 10]  = 10'(x);
    slot_y[10*s +: 10]  = 10'(y);
  endtask

  task automatic pulse(int line);
    next_line  = 10'(line);
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic wait_idle();
    cnt = 0; mx_x = 0; mx_y = 0;
    while (busy && cnt < 200) begin
      cnt++;
      if (int'(rif.rom_x) > mx_x) mx_x = int'(rif.rom_x);
      if (int'(rif.rom_y) > mx_y) mx_y = int'(rif.rom_y);
      tick();
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic sweep(int lo, int hi, int base);
    mask = '0; outside = 0;
    for (int v = lo; v <= hi; v++) begin
      DrawX = 10'(v);
      tick();
      if (pix_hit) begin
        if (v >= base && v < base + 16) mask[v - base] = 1'b1;
        else outside++;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 4; a++)
      for (int r = 0; r < 16; r++) bmp[a][r] = 16'($urandom);
    bmp[2][3] = 16'b0001001111001000;
    bmp[2][6] = 16'hA5C3;
    bmp[0][0][15 - 7] = 1'b1;

    repeat (3) tick();
    Reset_n = 1'b1;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_rom_x", rif.rom_x, 0);
    chk("rst_pix_hit", pix_hit, 0);
    chk("rst_overrun", overrun, 0);

    // Single hit: enemy at (100,50), line 53
    set_slot(0, 1, 2, 100, 50);
    pulse(53);
    wait_idle();
    chk("hit_busy_cycles", cnt, 20);
    chk("hit_rom_y", mx_y, 3);
    chk("hit_rom_x_max", mx_x, 15);
    pulse(200);
    wait_idle();
    chk("miss_after_hit_cycles", cnt, 4);
    sweep(90, 130, 100);
    chk("hit_mask", mask, 16'h13C8);
    chk("hit_outside", outside, 0);

    // Misses just above and below the sprite
    pulse(49);
    wait_idle();
    chk("miss49_cycles", cnt, 4);
    chk("miss49_rom_x", mx_x, 0);
    pulse(66);
    wait_idle();
    chk("miss66_cycles", cnt, 4);
    sweep(90, 130, -100);
    chk("miss_hits", outside, 0);

    // Priority: slots 0 and 2 overlap
    set_slot(0, 1, 0, 200, 10);
    set_slot(2, 1, 0, 200, 10);
    pulse(10);
    wait_idle();
    chk("prio_cycles", cnt, 36);
    pulse(10);
    wait_idle();
    DrawX = 10'd207;
    tick();
    chk("prio_hit", pix_hit, 1);
    chk("prio_slot", pix_slot, 0);

    // Overrun: restart 10 cycles into a hit fetch
    set_slot(2, 0, 0, 0, 0);
    set_slot(0, 1, 2, 100, 50);
    pulse(53);
    repeat (9) tick();
    pulse(53);
    chk("ovr_pulse", overrun, 1);
    wait_idle();
    chk("ovr_refetch_cycles", cnt, 20);
    DrawX = 10'd207;
    tick();
    chk("ovr_active_kept", pix_hit, 1);
    pulse(53);
    wait_idle();
    sweep(90, 130, 100);
    chk("ovr_new_mask", mask, 16'h13C8);

    // Vertical and horizontal wrap
    set_slot(0, 1, 2, 630, 1020);
    pulse(2);
    wait_idle();
    chk("wrap_rom_y", mx_y, 6);
    pulse(2);
    wait_idle();
    sweep(620, 639, 630);
    chk("wrap_mask", mask, 16'h03A5);
    chk("wrap_outside", outside, 0);
    sweep(0, 5, -100);
    chk("wrap_left_edge", outside, 0);

    // Reset mid-fetch
    set_slot(0, 1, 2, 100, 50);
    pulse(53);
    wait_idle();
    pulse(53);
    DrawX = 10'd103;
    repeat (5) tick();
    chk("pre_rst_hit", pix_hit, 1);
    #1 Reset_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_rom_x", rif.rom_x, 0);
    chk("async_rst_pix_hit", pix_hit, 0);
    tick();
    Reset_n = 1'b1;
    tick();
    sweep(90, 130, -100);
    chk("post_rst_hits", outside, 0);

    // Randomized lines, including short gaps that overrun
    for (int it = 0; it < 40; it++) begin
      for (int s = 0; s < N; s++)
        set_slot(s, ($urandom_range(0, 3) != 0), $urandom_range(0, 3),
                 $urandom_range(100, 160), 0);
      next_line = 10'($urandom);
      for (int s = 0; s < N; s++)
        slot_y[10*s +: 10] = next_line - 10'($urandom_range(0, 24));
      pulse(int'(next_line));
      repeat ($urandom_range(3, 80)) begin
        DrawX = 10'($urandom_range(95, 180));
        if (($urandom & 7) == 0) begin
          slot_en = N'($urandom);
          slot_x  = 40'({$urandom, $urandom});
        end
        tick();
      end
    end
    wait_idle();
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
`default_nettype wire
